// File: rtl/mio_arb_pkg.sv
// mio_arb_pkg: shared types and constants for the MIO bus arbiter.
package mio_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DMT_W  = 3;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_INST = 2'd2
  } arb_state_t;

  // Which requester owns the bus for the transfer being granted.
  typedef enum logic {
    SEL_INST = 1'b0,
    SEL_DATA = 1'b1
  } port_sel_t;

endpackage

// File: rtl/mio_timeout_cnt.sv
// mio_timeout_cnt: counts bus-wait cycles; expired is high in the TIMEOUT-th
// enabled cycle so the owner can abort on that clock edge.
module mio_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expired
);

  localparam int            CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  assign o_expired = i_enable && (r_cnt == LAST);

  // Wait-cycle counter; clear wins, holds once expired.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        r_cnt <= '0;
    else if (i_clear)                  r_cnt <= '0;
    else if (i_enable && !o_expired)   r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter: shares one memory bus between an instruction-fetch port and
// a data port, data-first with a starvation cap, plus a bus-wait timeout.
module mio_bus_arbiter
  import mio_arb_pkg::*;
#(
  parameter int TIMEOUT      = 255,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [DMT_W-1:0]  d_dmtype,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [DMT_W-1:0]  m_dmtype,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              mio_ready,
  output logic              stall
);

  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t        r_state, w_state_nxt;
  port_sel_t         w_sel;
  logic              w_grant, w_done, w_expired, w_turn, w_wait_clr;
  logic [SW-1:0]     r_starve;
  logic              r_m_req, r_m_we;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata, r_i_rdata, r_d_rdata;
  logic [DMT_W-1:0]  r_m_dmtype;
  logic              r_i_ack, r_i_err, r_d_ack, r_d_err;

  // An ack cycle is a turnaround: the acked requester's req is stale and is
  // ignored, and no grant is made at all so that the next arbitration sees
  // both requesters live (otherwise a held d_req could never build up
  // starvation pressure against a waiting fetch).
  assign w_turn     = r_i_ack | r_d_ack;
  assign w_wait_clr = ~r_m_req;

  mio_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk       (clk),
    .reset     (reset),
    .i_enable  (r_m_req),
    .i_clear   (w_wait_clr),
    .o_expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Arbitration and completion decode. Data wins unless the fetch has waited
  // through STARVE_LIMIT data grants; a lone data request is never blocked.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_sel       = SEL_DATA;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_turn) begin
          if (d_req && (r_starve != STARVE_MAX || !i_req)) begin
            w_grant     = 1'b1;
            w_sel       = SEL_DATA;
            w_state_nxt = ST_DATA;
          end else if (i_req) begin
            w_grant     = 1'b1;
            w_sel       = SEL_INST;
            w_state_nxt = ST_INST;
          end
        end
      end
      ST_DATA, ST_INST: begin
        if (mio_ready || w_expired) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Starvation counter: counts data grants that overtook a waiting fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve <= '0;
    end else if (w_grant && w_sel == SEL_INST) begin
      r_starve <= '0;
    end else if (w_grant && i_req && r_starve != STARVE_MAX) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // Bus drive and port responses; payload holds from grant to completion,
  // acks/errs are single-cycle pulses, rdata holds between acks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_m_dmtype <= '0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
      r_i_ack    <= 1'b0;
      r_i_err    <= 1'b0;
      r_d_ack    <= 1'b0;
      r_d_err    <= 1'b0;
    end else begin
      r_i_ack <= 1'b0;
      r_i_err <= 1'b0;
      r_d_ack <= 1'b0;
      r_d_err <= 1'b0;
      if (w_grant) begin
        r_m_req <= 1'b1;
        if (w_sel == SEL_DATA) begin
          r_m_we     <= d_we;
          r_m_addr   <= d_addr;
          r_m_wdata  <= d_wdata;
          r_m_dmtype <= d_dmtype;
        end else begin
          r_m_we     <= 1'b0;
          r_m_addr   <= i_addr;
          r_m_wdata  <= '0;
          r_m_dmtype <= '0;
        end
      end else if (w_done) begin
        // mio_ready takes priority over an expiry landing in the same cycle.
        r_m_req <= 1'b0;
        if (r_state == ST_DATA) begin
          r_d_ack   <= 1'b1;
          r_d_err   <= ~mio_ready;
          r_d_rdata <= mio_ready ? m_rdata : '0;
        end else begin
          r_i_ack   <= 1'b1;
          r_i_err   <= ~mio_ready;
          r_i_rdata <= mio_ready ? m_rdata : '0;
        end
      end
    end
  end

  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign m_dmtype = r_m_dmtype;
  assign i_rdata  = r_i_rdata;
  assign i_ack    = r_i_ack;
  assign i_err    = r_i_err;
  assign d_rdata  = r_d_rdata;
  assign d_ack    = r_d_ack;
  assign d_err    = r_d_err;
  assign stall    = (i_req & ~r_i_ack) | (d_req & ~r_d_ack);

endmodule
